// File: rtl/debug_pkg.sv
// debug_pkg: opcodes, reply bytes, size encodings, states and command kinds for debug_cmd_decoder.
// S_CSUM exists only when DBG_CHECKSUM_EN is defined.
package debug_pkg;
    localparam logic [7:0] OP_PAUSE  = 8'h01;
    localparam logic [7:0] OP_RESUME = 8'h02;
    localparam logic [7:0] OP_RESET  = 8'h03;
    localparam logic [7:0] OP_MEM_RD = 8'h10;
    localparam logic [7:0] OP_MEM_WR = 8'h14;
    localparam logic [7:0] OP_REG_RD = 8'h20;
    localparam logic [7:0] OP_REG_WR = 8'h21;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} size_t;
    // Receive states sort below S_ISSUE so "still parsing" is a single compare.
    typedef enum logic [2:0] {
        S_OPCODE, S_ADDR, S_DATA,
`ifdef DBG_CHECKSUM_EN
        S_CSUM,
`endif
        S_ISSUE, S_WAIT, S_REPLY
    } state_t;
    typedef enum logic [2:0] {
        CMD_NONE, CMD_PAUSE, CMD_RESUME, CMD_RESET, CMD_MEM_RD, CMD_MEM_WR, CMD_REG_RD, CMD_REG_WR
    } cmd_t;
    function automatic cmd_t decode(input logic [7:0] op);
        return op[1:0] != SZ_BAD && op[7:2] == OP_MEM_RD[7:2] ? CMD_MEM_RD :
               op[1:0] != SZ_BAD && op[7:2] == OP_MEM_WR[7:2] ? CMD_MEM_WR :
               op == OP_PAUSE  ? CMD_PAUSE  :
               op == OP_RESUME ? CMD_RESUME :
               op == OP_RESET  ? CMD_RESET  :
               op == OP_REG_RD ? CMD_REG_RD :
               op == OP_REG_WR ? CMD_REG_WR : CMD_NONE;
    endfunction
    function automatic logic has_addr(input cmd_t c);
        return c == CMD_MEM_RD || c == CMD_MEM_WR || c == CMD_REG_RD || c == CMD_REG_WR;
    endfunction
    function automatic logic has_data(input cmd_t c);
        return c == CMD_MEM_WR || c == CMD_REG_WR;
    endfunction
    function automatic logic is_rd(input cmd_t c);
        return c == CMD_MEM_RD || c == CMD_REG_RD;
    endfunction
endpackage

// File: rtl/debug_tx_serializer.sv
// debug_tx_serializer: sends a loaded word (4 bytes, MSB first) or single byte over tx_valid/tx_ready.
module debug_tx_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        word,
    input  logic [31:0] data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);
    logic [31:0] sh;
    logic [2:0]  left;
    assign tx_data = sh[31:24];
    always_ff @(posedge clk) begin
        if (reset) begin
            sh       <= '0;
            left     <= '0;
            tx_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                sh       <= word ? data : {data[7:0], 24'd0};
                left     <= word ? 3'd4 : 3'd1;
                tx_valid <= 1'b1;
            end else if (tx_valid && tx_ready) begin
                sh       <= sh << 8;
                left     <= left - 3'd1;
                tx_valid <= left != 3'd1;
                done     <= left == 3'd1;
            end
        end
    end
endmodule

// File: rtl/debug_cmd_decoder.sv
// debug_cmd_decoder: parses framed UART command bytes, strobes the debug adapter, replies ACK/NAK/read data.
// DBG_CHECKSUM_EN adds a trailing XOR checksum byte to every frame.
module debug_cmd_decoder
    import debug_pkg::*;
#(
    parameter int CLK_RATE      = 50,
    parameter int TIMEOUT_US    = 1000,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        mcu_busy,
    input  logic        error,
    input  logic [31:0] d_rd,
    output logic        valid,
    output logic        pause,
    output logic        resume,
    output logic        rst_req,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        reg_rd,
    output logic        reg_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] addr,
    output logic [31:0] d_in
);
    localparam logic [31:0] GAP_LIMIT = 32'(CLK_RATE * TIMEOUT_US);
    localparam logic [7:0]  SETTLE    = 8'(SETTLE_CYCLES);
`ifdef DBG_CHECKSUM_EN
    localparam state_t TAIL = S_CSUM;
    logic [7:0] csum;
`else
    localparam state_t TAIL = S_ISSUE;
`endif
    state_t      state, nxt;
    cmd_t        cmd, cmd_in;
    logic [1:0]  cnt, sz_sh;
    logic [31:0] a_sh, d_sh, a_nx, d_nx, tmr, ld_data;
    logic [7:0]  scnt;
    logic        in_field, gap_hit, settled, ld, ld_word, done, issue;
    assign in_field = state != S_OPCODE && state < S_ISSUE;
    assign gap_hit  = in_field && tmr == GAP_LIMIT;
    assign settled  = scnt >= SETTLE;
    assign cmd_in   = state == S_OPCODE ? decode(rx_data) : cmd;
    assign a_nx     = state == S_ADDR && rx_valid ? {a_sh[23:0], rx_data} : a_sh;
    assign d_nx     = state == S_DATA && rx_valid ? {d_sh[23:0], rx_data} : d_sh;
    assign issue    = nxt == S_ISSUE;
    assign ld       = nxt == S_REPLY && state != S_REPLY;
    assign ld_word  = state == S_WAIT && !error && is_rd(cmd);
    assign ld_data  = ld_word ? d_rd : {24'd0, state == S_WAIT && !error ? ACK : NAK};
    // A byte arriving on the expiry cycle takes priority over the gap timeout.
    always_comb begin
        nxt = state;
        case (state)
            S_OPCODE: nxt = !rx_valid ? S_OPCODE : cmd_in == CMD_NONE ? S_REPLY : has_addr(cmd_in) ? S_ADDR : TAIL;
            S_ADDR:   nxt = !rx_valid ? (gap_hit ? S_OPCODE : S_ADDR) : cnt != 2'd3 ? S_ADDR : has_data(cmd) ? S_DATA : TAIL;
            S_DATA:   nxt = !rx_valid ? (gap_hit ? S_OPCODE : S_DATA) : cnt != 2'd3 ? S_DATA : TAIL;
`ifdef DBG_CHECKSUM_EN
            S_CSUM:   nxt = !rx_valid ? (gap_hit ? S_OPCODE : S_CSUM) : rx_data == csum ? S_ISSUE : S_REPLY;
`endif
            S_ISSUE:  nxt = S_WAIT;
            S_WAIT:   nxt = settled && !mcu_busy ? S_REPLY : S_WAIT;
            S_REPLY:  nxt = done ? S_OPCODE : S_REPLY;
            default:  nxt = S_OPCODE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_OPCODE;
            cmd      <= CMD_NONE;
            cnt      <= '0;
            sz_sh    <= '0;
            a_sh     <= '0;
            d_sh     <= '0;
            tmr      <= '0;
            scnt     <= '0;
            valid    <= 1'b0;
            pause    <= 1'b0;
            resume   <= 1'b0;
            rst_req  <= 1'b0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            reg_rd   <= 1'b0;
            reg_wr   <= 1'b0;
            mem_size <= '0;
            addr     <= '0;
            d_in     <= '0;
`ifdef DBG_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            state <= nxt;
            a_sh  <= a_nx;
            d_sh  <= d_nx;
            tmr   <= rx_valid || !in_field ? '0 : tmr + 32'd1;
            cnt   <= state == S_OPCODE ? 2'd0 : rx_valid && (state == S_ADDR || state == S_DATA) ? cnt + 2'd1 : cnt;
            scnt  <= state == S_ISSUE ? 8'd1 : settled ? scnt : scnt + 8'd1;
            if (state == S_OPCODE && rx_valid) begin
                cmd   <= cmd_in;
                sz_sh <= rx_data[1:0];
            end
`ifdef DBG_CHECKSUM_EN
            if (rx_valid) csum <= state == S_OPCODE ? rx_data : csum ^ rx_data;
`endif
            valid   <= issue;
            pause   <= issue && cmd_in == CMD_PAUSE;
            resume  <= issue && cmd_in == CMD_RESUME;
            rst_req <= issue && cmd_in == CMD_RESET;
            mem_rd  <= issue && cmd_in == CMD_MEM_RD;
            mem_wr  <= issue && cmd_in == CMD_MEM_WR;
            reg_rd  <= issue && cmd_in == CMD_REG_RD;
            reg_wr  <= issue && cmd_in == CMD_REG_WR;
            if (issue) begin
                addr     <= a_nx;
                d_in     <= d_nx;
                mem_size <= sz_sh;
            end
        end
    end
    debug_tx_serializer u_tx (
        .clk      (clk),
        .reset    (reset),
        .load     (ld),
        .word     (ld_word),
        .data     (ld_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (done)
    );
endmodule

// File: tb/tb_debug_cmd_decoder.sv
// tb_debug_cmd_decoder: directed self-checking bench for debug_cmd_decoder.
// Frames get a trailing XOR byte automatically when DBG_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_debug_cmd_decoder;
    typedef logic [7:0] bq_t[$];
    logic        clk = 1'b0, reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        mcu_busy;
    logic        error = 1'b0;
    logic [31:0] d_rd = 32'h0;
    logic        valid, pause, resume, rst_req, mem_rd, mem_wr, reg_rd, reg_wr;
    logic [1:0]  mem_size;
    logic [31:0] addr, d_in;
    int checks = 0, errors = 0;
    int cyc = 0, busy_cfg = 0, busy_left = 0;
    int n_strobe = 0, vcyc = 0, first_tx = -1;
    logic [6:0]  last_cmd = '0;
    logic [31:0] last_addr = '0, last_din = '0;
    logic [1:0]  last_size = '0;
    bq_t txq, fr;

    debug_cmd_decoder #(.CLK_RATE(50), .TIMEOUT_US(2), .SETTLE_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mcu_busy(mcu_busy), .error(error), .d_rd(d_rd), .valid(valid),
        .pause(pause), .resume(resume), .rst_req(rst_req), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .reg_rd(reg_rd), .reg_wr(reg_wr),
        .mem_size(mem_size), .addr(addr), .d_in(d_in)
    );

    always #5 clk = ~clk;
    // Adapter model: busy while valid, then for busy_cfg further cycles.
    assign mcu_busy = valid || busy_left != 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        busy_left <= valid ? busy_cfg : busy_left != 0 ? busy_left - 1 : 0;
    end
    always @(negedge clk) begin
        if (valid) begin
            n_strobe++;
            vcyc = cyc;
            last_cmd = {pause, resume, rst_req, mem_rd, mem_wr, reg_rd, reg_wr};
            last_addr = addr;
            last_din = d_in;
            last_size = mem_size;
        end
        if (tx_valid && first_tx < 0) first_tx = cyc;
        if (tx_valid && tx_ready && !reset) txq.push_back(tx_data);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clr();
        n_strobe = 0; first_tx = -1; last_cmd = '0; txq.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bq_t f);
`ifdef DBG_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        foreach (f[i]) begin send_byte(f[i]); x ^= f[i]; end
        send_byte(x);
`else
        foreach (f[i]) send_byte(f[i]);
`endif
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (txq.size() < n && k < 300) begin tick(); k++; end
        checks++;
        if (txq.size() < n) begin errors++; $display("FAIL wait_tx got %0d bytes want %0d", txq.size(), n); end
        repeat (4) tick();
    endtask

    function automatic logic [31:0] txw();
        logic [31:0] w = '0;
        for (int i = 0; i < txq.size() && i < 4; i++) w = {w[23:0], txq[i]};
        return w;
    endfunction

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({valid, pause, resume, rst_req, mem_rd, mem_wr, reg_rd, reg_wr, tx_valid} !== 9'b0) begin
            errors++; $display("FAIL reset_strobes got %b want 0", {valid, pause, resume, rst_req, mem_rd, mem_wr, reg_rd, reg_wr, tx_valid});
        end
        checks++;
        if ({addr, d_in, mem_size} !== 66'b0) begin errors++; $display("FAIL reset_fields addr=%h d_in=%h size=%0d want 0", addr, d_in, mem_size); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_pause();
        clr(); fr = {8'h01}; send_frame(fr); wait_tx(1);
        checks++;
        if (n_strobe != 1 || last_cmd !== 7'b1000000) begin errors++; $display("FAIL pause_strobe n=%0d cmd=%b want 1 1000000", n_strobe, last_cmd); end
        checks++;
        if (txq.size() != 1 || txw() !== 32'h06) begin errors++; $display("FAIL pause_ack n=%0d got %h want 06", txq.size(), txw()); end
        checks++;
        if (first_tx - vcyc != 4) begin errors++; $display("FAIL pause_latency got %0d want 4", first_tx - vcyc); end
    endtask

    task automatic test_mem_rd();
        clr(); d_rd = 32'hDEADBEEF;
        fr = {8'h12, 8'h00, 8'h00, 8'h00, 8'h10}; send_frame(fr); wait_tx(4);
        checks++;
        if (n_strobe != 1 || last_cmd !== 7'b0001000) begin errors++; $display("FAIL mem_rd_strobe n=%0d cmd=%b want 1 0001000", n_strobe, last_cmd); end
        checks++;
        if (last_size !== 2'd2 || last_addr !== 32'h10) begin errors++; $display("FAIL mem_rd_fields size=%0d addr=%h want 2 00000010", last_size, last_addr); end
        checks++;
        if (txq.size() != 4 || txw() !== 32'hDEADBEEF) begin errors++; $display("FAIL mem_rd_data n=%0d got %h want deadbeef", txq.size(), txw()); end
    endtask

    task automatic test_reg_wr_busy();
        clr(); busy_cfg = 6;
        fr = {8'h21, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h2A}; send_frame(fr); wait_tx(1);
        busy_cfg = 0;
        checks++;
        if (n_strobe != 1 || last_cmd !== 7'b0000001) begin errors++; $display("FAIL reg_wr_strobe n=%0d cmd=%b want 1 0000001", n_strobe, last_cmd); end
        checks++;
        if (last_addr !== 32'h5 || last_din !== 32'h2A) begin errors++; $display("FAIL reg_wr_fields addr=%h d_in=%h want 5 2a", last_addr, last_din); end
        checks++;
        if (txq.size() != 1 || txw() !== 32'h06) begin errors++; $display("FAIL reg_wr_ack n=%0d got %h want 06", txq.size(), txw()); end
        checks++;
        if (first_tx - vcyc != 8) begin errors++; $display("FAIL reg_wr_busy_latency got %0d want 8", first_tx - vcyc); end
    endtask

    task automatic test_mem_wr_error();
        clr(); error = 1'b1;
        fr = {8'h16, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}; send_frame(fr); wait_tx(1);
        error = 1'b0;
        checks++;
        if (n_strobe != 1 || last_cmd !== 7'b0000100 || last_size !== 2'd2) begin
            errors++; $display("FAIL mem_wr_strobe n=%0d cmd=%b size=%0d want 1 0000100 2", n_strobe, last_cmd, last_size);
        end
        checks++;
        if (last_addr !== 32'h100 || last_din !== 32'h11223344) begin errors++; $display("FAIL mem_wr_fields addr=%h d_in=%h want 100 11223344", last_addr, last_din); end
        checks++;
        if (txq.size() != 1 || txw() !== 32'h15) begin errors++; $display("FAIL mem_wr_err_nak n=%0d got %h want 15", txq.size(), txw()); end
    endtask

    task automatic test_bad_opcode();
        clr(); send_byte(8'h7F); wait_tx(1);
        checks++;
        if (n_strobe != 0 || txq.size() != 1 || txw() !== 32'h15) begin errors++; $display("FAIL op7f_nak n=%0d bytes=%0d got %h want 0 1 15", n_strobe, txq.size(), txw()); end
        clr(); send_byte(8'h13); wait_tx(1);
        checks++;
        if (n_strobe != 0 || txq.size() != 1 || txw() !== 32'h15) begin errors++; $display("FAIL op13_nak n=%0d bytes=%0d got %h want 0 1 15", n_strobe, txq.size(), txw()); end
    endtask

    task automatic test_timeout();
        clr(); send_byte(8'h10); send_byte(8'h00);
        repeat (120) tick();
        checks++;
        if (n_strobe != 0 || txq.size() != 0) begin errors++; $display("FAIL timeout_silent n=%0d bytes=%0d want 0 0", n_strobe, txq.size()); end
        fr = {8'h01}; send_frame(fr); wait_tx(1);
        checks++;
        if (n_strobe != 1 || last_cmd !== 7'b1000000 || txw() !== 32'h06) begin
            errors++; $display("FAIL timeout_recover n=%0d cmd=%b got %h want 1 1000000 06", n_strobe, last_cmd, txw());
        end
        clr(); d_rd = 32'hCAFEF00D;
        send_byte(8'h20);
        repeat (90) tick();
        fr = {8'h00, 8'h00, 8'h00, 8'h07};
        foreach (fr[i]) send_byte(fr[i]);
`ifdef DBG_CHECKSUM_EN
        send_byte(8'h27);
`endif
        wait_tx(4);
        checks++;
        if (n_strobe != 1 || last_cmd !== 7'b0000010 || last_addr !== 32'h7) begin
            errors++; $display("FAIL short_gap_reg_rd n=%0d cmd=%b addr=%h want 1 0000010 7", n_strobe, last_cmd, last_addr);
        end
        checks++;
        if (txq.size() != 4 || txw() !== 32'hCAFEF00D) begin errors++; $display("FAIL short_gap_data n=%0d got %h want cafef00d", txq.size(), txw()); end
    endtask

    task automatic test_tx_stall();
        int k = 0;
        clr(); tx_ready = 1'b0; d_rd = 32'h12345678;
        fr = {8'h20, 8'h00, 8'h00, 8'h00, 8'h01}; send_frame(fr);
        while (!tx_valid && k < 100) begin tick(); k++; end
        checks++;
        if (!tx_valid) begin errors++; $display("FAIL stall_wait tx_valid=%b want 1", tx_valid); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h12) begin errors++; $display("FAIL stall_hold cycle %0d valid=%b data=%h want 1 12", i, tx_valid, tx_data); end
        end
        tick(); tx_ready = 1'b1; wait_tx(4);
        checks++;
        if (txq.size() != 4 || txw() !== 32'h12345678) begin errors++; $display("FAIL stall_data n=%0d got %h want 12345678", txq.size(), txw()); end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        clr(); tx_ready = 1'b0;
        fr = {8'h01}; send_frame(fr);
        while (!tx_valid && k < 100) begin tick(); k++; end
        reset = 1'b1; tick();
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_reply tx_valid=%b want 0", tx_valid); end
        reset = 1'b0; tx_ready = 1'b1; tick();
        clr(); send_byte(8'h21); send_byte(8'h00);
        reset = 1'b1; tick(); reset = 1'b0; tick();
        fr = {8'h02}; send_frame(fr); wait_tx(1);
        checks++;
        if (n_strobe != 1 || last_cmd !== 7'b0100000 || txw() !== 32'h06) begin
            errors++; $display("FAIL reset_mid_frame n=%0d cmd=%b got %h want 1 0100000 06", n_strobe, last_cmd, txw());
        end
    endtask

`ifdef DBG_CHECKSUM_EN
    task automatic test_checksum();
        clr(); send_byte(8'h02); send_byte(8'h02); wait_tx(1);
        checks++;
        if (n_strobe != 1 || last_cmd !== 7'b0100000 || txw() !== 32'h06) begin
            errors++; $display("FAIL csum_good n=%0d cmd=%b got %h want 1 0100000 06", n_strobe, last_cmd, txw());
        end
        clr(); send_byte(8'h02); send_byte(8'h00); wait_tx(1);
        checks++;
        if (n_strobe != 0 || txw() !== 32'h15) begin errors++; $display("FAIL csum_bad n=%0d got %h want 0 15", n_strobe, txw()); end
    endtask
`endif

    initial begin
        test_reset();
        test_pause();
        test_mem_rd();
        test_reg_wr_busy();
        test_mem_wr_error();
        test_bad_opcode();
        test_timeout();
        test_tx_stall();
        test_reset_mid();
`ifdef DBG_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
